// File: rtl/adjust_keys.sv
// adjust_keys: turns the raw active-low DE1-SoC push buttons into clean,
// frame-aligned, one-clock inc/dec step pulses for the contrast stage.
// Each key is synchronised and debounced. Simultaneous presses cancel each
// other. A held key steps once on the first frame, then auto-repeats.
module adjust_keys #(
    parameter int DB_CYCLES    = 50000,
    parameter int DB_W         = 16,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 4,
    parameter int FR_W         = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_en,
    input  logic key_inc_n,
    input  logic key_dec_n,
    output logic inc,
    output logic dec,
    output logic held
);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO  = {DB_W{1'b0}};
    localparam logic [FR_W-1:0] FR_DELAY = FR_W'(REPEAT_DELAY);
    localparam logic [FR_W-1:0] FR_RATE  = FR_W'(REPEAT_RATE);
    localparam logic [FR_W-1:0] FR_ONE   = FR_W'(1);
    localparam logic [FR_W-1:0] FR_ZERO  = {FR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    // Bit 0 carries the increase key and bit 1 the decrease key.
    // All key levels stay active-low: 1 means released.
    logic [1:0]            sync1_r;
    logic [1:0]            sync2_r;
    logic [1:0]            db_r;
    logic [1:0]            db_nx_s;
    logic [1:0][DB_W-1:0]  db_cnt_r;
    logic [1:0][DB_W-1:0]  db_cnt_nx_s;

    state_t                state_r;
    state_t                state_nx_s;
    logic                  dir_r;        // 1 = increase, 0 = decrease
    logic                  dir_nx_s;
    logic [FR_W-1:0]       fr_cnt_r;
    logic [FR_W-1:0]       fr_cnt_nx_s;
    logic                  pulse_s;
    logic                  inc_press_s;
    logic                  dec_press_s;
    logic                  sel_inc_s;
    logic                  sel_dec_s;
    logic                  keep_s;
    logic                  inc_r;
    logic                  dec_r;
    logic                  held_r;

    // Two-flop synchronisers for both asynchronous key levels; they reset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
        end else begin
            sync1_r <= {key_dec_n, key_inc_n};
            sync2_r <= sync1_r;
        end
    end

    // Debounce next state: a level change is accepted after DB_CYCLES consecutive disagreeing clocks.
    always_comb begin
        db_nx_s     = db_r;
        db_cnt_nx_s = {DB_ZERO, DB_ZERO};
        for (int k = 0; k < 2; k++) begin
            if (sync2_r[k] == db_r[k]) begin
                db_cnt_nx_s[k] = DB_ZERO;
            end else if (db_cnt_r[k] == DB_LAST) begin
                db_nx_s[k]     = ~db_r[k];
                db_cnt_nx_s[k] = DB_ZERO;
            end else begin
                db_cnt_nx_s[k] = db_cnt_r[k] + DB_ONE;
            end
        end
    end

    // Debounced key levels and their stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r     <= 2'b11;
            db_cnt_r <= {DB_ZERO, DB_ZERO};
        end else begin
            db_r     <= db_nx_s;
            db_cnt_r <= db_cnt_nx_s;
        end
    end

    // Key selection: exactly one key pressed selects it; both pressed selects nothing.
    // keep_s is low when the selection no longer matches the latched direction.
    always_comb begin
        inc_press_s = ~db_r[0];
        dec_press_s = ~db_r[1];
        sel_inc_s   = inc_press_s & ~dec_press_s;
        sel_dec_s   = dec_press_s & ~inc_press_s;
        keep_s      = dir_r ? sel_inc_s : sel_dec_s;
    end

    // Step FSM next state: an abort has priority over a coincident frame_en.
    always_comb begin
        state_nx_s  = state_r;
        dir_nx_s    = dir_r;
        fr_cnt_nx_s = fr_cnt_r;
        pulse_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_inc_s || sel_dec_s) begin
                    dir_nx_s   = sel_inc_s;
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!keep_s) begin
                    state_nx_s = ST_IDLE;
                end else if (frame_en) begin
                    pulse_s     = 1'b1;
                    fr_cnt_nx_s = FR_DELAY;
                    state_nx_s  = ST_HOLD;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!keep_s) begin
                    state_nx_s = ST_IDLE;
                end else if (frame_en) begin
                    // When the count is 1, decrementing it reaches 0, so this frame steps.
                    // A count of 0 is treated the same way, which acts as saturation.
                    if (fr_cnt_r <= FR_ONE) begin
                        pulse_s     = 1'b1;
                        fr_cnt_nx_s = FR_RATE;
                        state_nx_s  = ST_REPEAT;
                    end else begin
                        fr_cnt_nx_s = fr_cnt_r - FR_ONE;
                        state_nx_s  = state_r;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched direction and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            dir_r    <= 1'b0;
            fr_cnt_r <= FR_ZERO;
        end else begin
            state_r  <= state_nx_s;
            dir_r    <= dir_nx_s;
            fr_cnt_r <= fr_cnt_nx_s;
        end
    end

    // Registered outputs: a pulse appears on the clock after its qualifying frame_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_r  <= 1'b0;
            dec_r  <= 1'b0;
            held_r <= 1'b0;
        end else begin
            inc_r  <= pulse_s & dir_r;
            dec_r  <= pulse_s & ~dir_r;
            held_r <= (state_nx_s != ST_IDLE);
        end
    end

    assign inc  = inc_r;
    assign dec  = dec_r;
    assign held = held_r;

endmodule
